izhikevich_array: RTL and testbench
===================================

// Module: izhikevich_array
// PURPOSE
// Time-multiplexed bank of NUM_NEURONS Izhikevich neurons sharing one update datapath.
// Each start pulse advances every neuron by one timestep, sweeping index 0..NUM_NEURONS-1.
// Spiking indices are emitted on a buffered valid/ready stream. Sits between the
// host config bus and downstream synapse/router logic.
// PARAMETERS
// WIDTH          18      signed fixed-point width; format Q2.(WIDTH-2), 0x1_6666 = 1.4
// NUM_NEURONS    16      neurons in bank (>=2)
// IDX_W          $clog2(NUM_NEURONS)  neuron index width
// SPK_FIFO_DEPTH 4       spike FIFO entries (power of 2)
// V_INIT         18'sh3_4CCD  reset v (-0.7)
// U_INIT         18'sh3_CCCD  reset u (-0.2)
// PORTS
// clk        in   1      clock
// reset_n    in   1      synchronous reset, active low
// start      in   1      pulse: run one timestep sweep
// busy       out  1      sweep in progress
// done       out  1      1-cycle pulse, sweep complete
// cfg_we     in   1      config write strobe
// cfg_addr   in   IDX_W  neuron index
// cfg_sel    in   4      field: 0 v,1 u,2 a_sh,3 b_sh,4 c,5 d,6 I,7 v_th(global)
// cfg_data   in   WIDTH  write data (a_sh/b_sh use [3:0])
// cfg_err    out  1      1-cycle pulse: write dropped (busy)
// rd_addr    in   IDX_W  readback index
// rd_sel     in   4      readback field (same map; 8 = spike count)
// rd_data    out  WIDTH  registered readback, 1-cycle latency
// spk_valid  out  1      spike FIFO non-empty
// spk_ready  in   1      consumer accepts head
// spk_idx    out  IDX_W  index of spiking neuron at FIFO head
// BEHAVIOUR
// - Reset: every v=V_INIT, u=U_INIT, a_sh=6, b_sh=2, c=0x3_8000, d=0x0_051E, I=0,
//   v_th=0x0_4CCC; FIFO empty; busy=done=cfg_err=spk_valid=0, rd_data=0, FSM IDLE.
// - FSM: IDLE -(start)-> READ -> UPDATE -> (idx==last ? DONE : READ); DONE -> IDLE.
//   READ latches neuron idx state; UPDATE writes back. 2 cycles/neuron, no stall:
//   start sampled in cycle 0, done pulses in cycle 2*NUM_NEURONS+1.
// - start while busy ignored. busy high from cycle after start until done cycle incl.
// - Update (all shifts arithmetic, products truncated as {p[2W-1],p[2W-4:W-2]}):
//   if v > v_th: v<=c, u<=sat(u+d), push idx to FIFO.
//   else: v<=sat(v + ((v*v + v + (v>>>2) + (C14>>>2) - (u>>>2) + (I>>>2))>>>2)),
//         u<=sat(u + ((((v>>>b_sh) - u)>>>a_sh)>>>4)), C14=0x1_6666.
//   Intermediates WIDTH+4 bits; sat clamps to [0x2_0000, 0x1_FFFF].
// - Spike FIFO full in UPDATE of a spiking neuron: FSM holds UPDATE (no writeback)
//   until a slot frees; simultaneous pop+push on full proceeds same cycle.
// - FIFO order = index order; spk_idx stable while spk_valid && !spk_ready.
// - Config writes while busy: dropped, cfg_err pulses; otherwise applied next edge.
//   Readback of the neuron being written returns new value one cycle later.
// - reset_n low mid-sweep: sweep aborted, all state reloaded, FIFO flushed, no done.
// CONFIGURATION
// - IZH_SPIKE_COUNT_EN defined: per-neuron 16-bit saturating spike counter,
//   cleared by reset or cfg write sel 8; rd_sel 8 returns zero-extended count.
// - Not defined: no counters; rd_sel 8 returns 0, cfg sel 8 write ignored (no cfg_err).
// TESTING
// - Reset, read all fields of neurons 0 and last -> reset values above, spk_valid=0.
// - Neuron 3 v=0x0_5999 (0.35), start -> spk_idx=3, v=0x3_8000, u=0x3_CCCD+0x0_051E; done @ cycle 33.
// - All 16 v=0x0_5999, spk_ready=0 -> stall after 4 spikes, busy held; release -> idx 0..15 in order.
// - v_th=0x1_FFFF, neuron 0 v=0x1_E666 -> v saturates to 0x1_FFFF, no spike.
// - reset_n low in cycle 10 of sweep -> no done, FIFO empty, v=V_INIT; cfg write while busy -> cfg_err.
// - IZH_SPIKE_COUNT_EN: neuron 5 spikes on 3 sweeps -> rd_sel 8 returns 3; undefined -> 0.

Source files
------------

// File: rtl/izhikevich_array.sv
// izhikevich_array
//   Time-multiplexed bank of NUM_NEURONS Izhikevich neurons sharing a single
//   update datapath. A start pulse sweeps every neuron once (index 0 upward,
//   two cycles per neuron: READ latches the state, UPDATE writes it back).
//   Spiking indices are queued in a small FIFO and offered on a valid/ready
//   stream.
//
//   Optional feature: define IZH_SPIKE_COUNT_EN to add a per-neuron 16-bit
//   saturating spike counter (readback field 8, cleared by a field-8 write).
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   start / busy / done   sweep request, sweep in progress, 1-cycle completion
//   cfg_we/addr/sel/data  configuration write (dropped with cfg_err when busy)
//   rd_addr/rd_sel        readback select, rd_data registered (1-cycle latency)
//   spk_valid/ready/idx   spike index stream (FIFO head)
//
// Field map (cfg_sel / rd_sel): 0 v, 1 u, 2 a_sh, 3 b_sh, 4 c, 5 d, 6 I,
//   7 v_th (global), 8 spike count.
module izhikevich_array #(
  parameter int WIDTH          = 18,
  parameter int NUM_NEURONS    = 16,
  parameter int IDX_W          = $clog2(NUM_NEURONS),
  parameter int SPK_FIFO_DEPTH = 4,
  parameter logic signed [WIDTH-1:0] V_INIT = 18'sh3_4CCD,
  parameter logic signed [WIDTH-1:0] U_INIT = 18'sh3_CCCD
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [3:0]       cfg_sel,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             cfg_err,
  input  logic [IDX_W-1:0] rd_addr,
  input  logic [3:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             spk_valid,
  input  logic             spk_ready,
  output logic [IDX_W-1:0] spk_idx
);

  localparam int XW = WIDTH + 4;                  // intermediate width
  localparam int PW = $clog2(SPK_FIFO_DEPTH);     // FIFO pointer width
  localparam int CW = PW + 1;                     // FIFO occupancy width

  localparam logic signed [WIDTH-1:0] C14     = 18'sh1_6666;
  localparam logic signed [WIDTH-1:0] C_RST   = 18'sh3_8000;
  localparam logic signed [WIDTH-1:0] D_RST   = 18'sh0_051E;
  localparam logic signed [WIDTH-1:0] VTH_RST = 18'sh0_4CCC;
  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [3:0]              A_RST   = 4'd6;
  localparam logic [3:0]              B_RST   = 4'd2;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CW-1:0]           FIFO_FULL = CW'(SPK_FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Sign-extend a WIDTH value to the intermediate width.
  function automatic logic signed [XW-1:0] sx(input logic signed [WIDTH-1:0] x);
    return {{(XW-WIDTH){x[WIDTH-1]}}, x};
  endfunction

  // Fixed-point product, keeping the sign bit and the Q2 window of the result.
  function automatic logic signed [WIDTH-1:0] qmul(input logic signed [WIDTH-1:0] a,
                                                   input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p = a * b;
    return {p[2*WIDTH-1], p[2*WIDTH-4:WIDTH-2]};
  endfunction

  // Clamp an intermediate value into the representable WIDTH range.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] x);
    logic signed [WIDTH-1:0] r;
    if (x > sx(SAT_MAX)) begin
      r = SAT_MAX;
    end else if (x < sx(SAT_MIN)) begin
      r = SAT_MIN;
    end else begin
      r = x[WIDTH-1:0];
    end
    return r;
  endfunction

  // Neuron state and parameters
  logic signed [WIDTH-1:0] v_mem_r [NUM_NEURONS];
  logic signed [WIDTH-1:0] u_mem_r [NUM_NEURONS];
  logic        [3:0]       a_mem_r [NUM_NEURONS];
  logic        [3:0]       b_mem_r [NUM_NEURONS];
  logic signed [WIDTH-1:0] c_mem_r [NUM_NEURONS];
  logic signed [WIDTH-1:0] d_mem_r [NUM_NEURONS];
  logic signed [WIDTH-1:0] i_mem_r [NUM_NEURONS];
  logic signed [WIDTH-1:0] v_th_r;
`ifdef IZH_SPIKE_COUNT_EN
  logic        [15:0]      cnt_mem_r [NUM_NEURONS];
`endif

  // Sweep control and latched operands
  state_t                  state_r, state_s;
  logic                    busy_r, busy_s, done_r, done_s;
  logic [IDX_W-1:0]        idx_r;
  logic signed [WIDTH-1:0] lv_r, lu_r, lc_r, ld_r, li_r;
  logic        [3:0]       la_r, lb_r;

  // Datapath
  logic signed [XW-1:0]    vx_s, ux_s, sum_s, du_s;
  logic signed [WIDTH-1:0] v_nxt_s, u_nxt_s, u_spk_s;
  logic                    spike_s;

  // Spike FIFO
  logic [IDX_W-1:0]        fifo_mem_r [SPK_FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]           fcnt_r;
  logic                    full_s, pop_s, push_s, stall_s, wb_s;

  // Config / readback
  logic                    cfg_ok_s, sel_ok_s, cfg_err_r;
  logic [WIDTH-1:0]        rd_mux_s, rd_data_r;

  // Neuron update arithmetic on the operands latched in READ.
  always_comb begin
    vx_s    = sx(lv_r);
    ux_s    = sx(lu_r);
    sum_s   = sx(qmul(lv_r, lv_r)) + vx_s + (vx_s >>> 2'd2) + (sx(C14) >>> 2'd2)
              - (ux_s >>> 2'd2) + (sx(li_r) >>> 2'd2);
    v_nxt_s = sat(vx_s + (sum_s >>> 2'd2));
    du_s    = (((vx_s >>> lb_r) - ux_s) >>> la_r) >>> 3'd4;
    u_nxt_s = sat(ux_s + du_s);
    u_spk_s = sat(ux_s + sx(ld_r));
    spike_s = (lv_r > v_th_r);
  end

  // FIFO handshake; a spiking neuron cannot retire while the FIFO is full,
  // unless the consumer frees the head in the same cycle.
  always_comb begin
    full_s  = (fcnt_r == FIFO_FULL);
    pop_s   = (fcnt_r != {CW{1'b0}}) && spk_ready;
    push_s  = (state_r == S_UPDATE) && spike_s && (!full_s || pop_s);
    stall_s = (state_r == S_UPDATE) && spike_s && full_s && !pop_s;
    wb_s    = (state_r == S_UPDATE) && !stall_s;
  end

  // Next-state logic of the sweep FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_READ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READ:   state_s = S_UPDATE;
      S_UPDATE: begin
        if (stall_s) begin
          state_s = S_UPDATE;
        end else if (idx_r == LAST_IDX) begin
          state_s = S_DONE;
        end else begin
          state_s = S_READ;
        end
      end
      S_DONE:   state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so they can be registered.
  always_comb begin
    busy_s = (state_s != S_IDLE);
    done_s = (state_s == S_DONE);
  end

  // FSM state, status outputs and the neuron index.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      if ((state_r == S_IDLE) && start) begin
        idx_r <= {IDX_W{1'b0}};
      end else if (wb_s) begin
        idx_r <= idx_r + 1'b1;
      end
    end
  end

  // Operand latch for the neuron being updated.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lv_r <= '0; lu_r <= '0; lc_r <= '0; ld_r <= '0; li_r <= '0;
      la_r <= 4'd0; lb_r <= 4'd0;
    end else if (state_r == S_READ) begin
      lv_r <= v_mem_r[idx_r];
      lu_r <= u_mem_r[idx_r];
      lc_r <= c_mem_r[idx_r];
      ld_r <= d_mem_r[idx_r];
      li_r <= i_mem_r[idx_r];
      la_r <= a_mem_r[idx_r];
      lb_r <= b_mem_r[idx_r];
    end
  end

  // Config writes are only accepted while idle, so they never collide with
  // datapath write-back.
  always_comb begin
`ifdef IZH_SPIKE_COUNT_EN
    sel_ok_s = (cfg_sel <= 4'd8);
`else
    sel_ok_s = (cfg_sel <= 4'd7);
`endif
    cfg_ok_s = cfg_we && !busy_r;
  end

  // Neuron state/parameter storage: reset, config write, or sweep write-back.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_mem_r[i] <= V_INIT;
        u_mem_r[i] <= U_INIT;
        a_mem_r[i] <= A_RST;
        b_mem_r[i] <= B_RST;
        c_mem_r[i] <= C_RST;
        d_mem_r[i] <= D_RST;
        i_mem_r[i] <= '0;
      end
      v_th_r <= VTH_RST;
    end else if (cfg_ok_s) begin
      case (cfg_sel)
        4'd0:    v_mem_r[cfg_addr] <= cfg_data;
        4'd1:    u_mem_r[cfg_addr] <= cfg_data;
        4'd2:    a_mem_r[cfg_addr] <= cfg_data[3:0];
        4'd3:    b_mem_r[cfg_addr] <= cfg_data[3:0];
        4'd4:    c_mem_r[cfg_addr] <= cfg_data;
        4'd5:    d_mem_r[cfg_addr] <= cfg_data;
        4'd6:    i_mem_r[cfg_addr] <= cfg_data;
        4'd7:    v_th_r            <= cfg_data;
        default: ;
      endcase
    end else if (wb_s) begin
      v_mem_r[idx_r] <= spike_s ? lc_r : v_nxt_s;
      u_mem_r[idx_r] <= spike_s ? u_spk_s : u_nxt_s;
    end
  end

`ifdef IZH_SPIKE_COUNT_EN
  // Per-neuron saturating spike counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        cnt_mem_r[i] <= 16'd0;
      end
    end else if (cfg_ok_s && (cfg_sel == 4'd8)) begin
      cnt_mem_r[cfg_addr] <= 16'd0;
    end else if (push_s && (cnt_mem_r[idx_r] != 16'hFFFF)) begin
      cnt_mem_r[idx_r] <= cnt_mem_r[idx_r] + 16'd1;
    end
  end
`endif

  // Spike FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SPK_FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= {IDX_W{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      fcnt_r   <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= idx_r;
        wr_ptr_r             <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   fcnt_r <= fcnt_r + 1'b1;
        2'b01:   fcnt_r <= fcnt_r - 1'b1;
        default: fcnt_r <= fcnt_r;
      endcase
    end
  end

  // Readback field selection.
  always_comb begin
    rd_mux_s = {WIDTH{1'b0}};
    case (rd_sel)
      4'd0:    rd_mux_s = v_mem_r[rd_addr];
      4'd1:    rd_mux_s = u_mem_r[rd_addr];
      4'd2:    rd_mux_s = {{(WIDTH-4){1'b0}}, a_mem_r[rd_addr]};
      4'd3:    rd_mux_s = {{(WIDTH-4){1'b0}}, b_mem_r[rd_addr]};
      4'd4:    rd_mux_s = c_mem_r[rd_addr];
      4'd5:    rd_mux_s = d_mem_r[rd_addr];
      4'd6:    rd_mux_s = i_mem_r[rd_addr];
      4'd7:    rd_mux_s = v_th_r;
`ifdef IZH_SPIKE_COUNT_EN
      4'd8:    rd_mux_s = {{(WIDTH-16){1'b0}}, cnt_mem_r[rd_addr]};
`endif
      default: rd_mux_s = {WIDTH{1'b0}};
    endcase
  end

  // Registered readback data and the dropped-write error pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data_r <= {WIDTH{1'b0}};
      cfg_err_r <= 1'b0;
    end else begin
      rd_data_r <= rd_mux_s;
      cfg_err_r <= cfg_we && busy_r && sel_ok_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign cfg_err   = cfg_err_r;
  assign rd_data   = rd_data_r;
  assign spk_valid = (fcnt_r != {CW{1'b0}});
  assign spk_idx   = fifo_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_izhikevich_array.sv
module tb_izhikevich_array;
  localparam int W   = 18;
  localparam int N   = 16;
  localparam int IW  = 4;
  localparam int C14 = 32'sh0001_6666;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, cfg_err, spk_valid;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_addr = '0;
  logic [3:0]    cfg_sel = 4'd0;
  logic [W-1:0]  cfg_data = '0;
  logic [IW-1:0] rd_addr = '0;
  logic [3:0]    rd_sel = 4'd0;
  logic [W-1:0]  rd_data;
  logic          spk_ready = 1'b0;
  logic [IW-1:0] spk_idx;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model of the neuron bank
  int m_v[N], m_u[N], m_a[N], m_b[N], m_c[N], m_d[N], m_i[N], m_cnt[N];
  int m_vth;
  int exp_q[$];

  always #5 clk = ~clk;

  izhikevich_array dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_idx(spk_idx)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int s18(input logic [17:0] x);
    return x[17] ? int'(x) - 262144 : int'(x);
  endfunction

  function automatic int sat18(input int x);
    if (x > 131071) return 131071;
    if (x < -131072) return -131072;
    return x;
  endfunction

  // Q2.16 product: full 36-bit product, keep sign bit and bits 32..16.
  function automatic int qmul_m(input int a, input int b);
    longint      p;
    logic [63:0] lp;
    int          low;
    p   = longint'(a) * longint'(b);
    lp  = p;
    low = int'(lp[32:16]);
    return lp[35] ? low - 131072 : low;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_v[k] = s18(18'h3_4CCD); m_u[k] = s18(18'h3_CCCD);
      m_a[k] = 6; m_b[k] = 2;
      m_c[k] = s18(18'h3_8000); m_d[k] = 32'h0000_051E;
      m_i[k] = 0; m_cnt[k] = 0;
    end
    m_vth = 32'h0000_4CCC;
  endtask

  // One timestep over the whole bank; expected spikes appended in index order.
  task automatic model_sweep();
    for (int k = 0; k < N; k++) begin
      int v, u, sum, du;
      v = m_v[k];
      u = m_u[k];
      if (v > m_vth) begin
        m_v[k] = m_c[k];
        m_u[k] = sat18(u + m_d[k]);
        exp_q.push_back(k);
        if (m_cnt[k] < 65535) m_cnt[k]++;
      end else begin
        sum = qmul_m(v, v) + v + (v >>> 2) + (C14 >>> 2) - (u >>> 2) + (m_i[k] >>> 2);
        m_v[k] = sat18(v + (sum >>> 2));
        du = (((v >>> m_b[k]) - u) >>> m_a[k]) >>> 4;
        m_u[k] = sat18(u + du);
      end
    end
  endtask

  function automatic logic [31:0] exp_field(input int k, input int sel);
    case (sel)
      0: return 32'(m_v[k]) & 32'h3FFFF;
      1: return 32'(m_u[k]) & 32'h3FFFF;
      2: return 32'(m_a[k]);
      3: return 32'(m_b[k]);
      4: return 32'(m_c[k]) & 32'h3FFFF;
      5: return 32'(m_d[k]) & 32'h3FFFF;
      6: return 32'(m_i[k]) & 32'h3FFFF;
      7: return 32'(m_vth) & 32'h3FFFF;
`ifdef IZH_SPIKE_COUNT_EN
      8: return 32'(m_cnt[k]);
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic cfg_write(input int k, input int sel, input logic [17:0] data);
    cfg_we = 1'b1; cfg_addr = IW'(k); cfg_sel = 4'(sel); cfg_data = data;
    tick();
    cfg_we = 1'b0;
    case (sel)
      0: m_v[k] = s18(data);
      1: m_u[k] = s18(data);
      2: m_a[k] = int'(data[3:0]);
      3: m_b[k] = int'(data[3:0]);
      4: m_c[k] = s18(data);
      5: m_d[k] = s18(data);
      6: m_i[k] = s18(data);
      7: m_vth  = s18(data);
      8: m_cnt[k] = 0;
      default: ;
    endcase
  endtask

  task automatic rd_field(input int k, input int sel, output logic [17:0] val);
    rd_addr = IW'(k); rd_sel = 4'(sel);
    tick();
    val = rd_data;
  endtask

  task automatic check_neuron(input int k);
    logic [17:0] val;
    for (int sel = 0; sel <= 8; sel++) begin
      rd_field(k, sel, val);
      check_eq($sformatf("n%0d_sel%0d", k, sel), 32'(val), exp_field(k, sel));
    end
  endtask

  // mode 0: random ready, 1: always ready, 2: ready held low until cycle 60.
  task automatic run_sweep(input int mode, input bit inject);
    int cyc, popped, exp_n;
    bit seen_done;
    exp_q.delete();
    model_sweep();
    exp_n = exp_q.size();
    popped = 0;
    seen_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check_eq("busy_cycle1", 32'(busy), 32'd1);
    while (!seen_done && cyc < 3000) begin
      case (mode)
        0:       spk_ready = 1'($urandom_range(0, 1));
        1:       spk_ready = 1'b1;
        default: spk_ready = (cyc >= 60);
      endcase
      if (inject && cyc == 5) begin
        cfg_we = 1'b1; cfg_addr = IW'(7); cfg_sel = 4'd0; cfg_data = 18'h0_1234;
      end
      if (inject && cyc == 6) begin
        cfg_we = 1'b0;
        check_eq("cfg_err_busy", 32'(cfg_err), 32'd1);
      end
      if (mode == 2 && cyc == 59) begin
        check_eq("stall_busy", 32'(busy), 32'd1);
        check_eq("stall_valid", 32'(spk_valid), 32'd1);
        check_eq("stall_pops", 32'(popped), 32'd0);
      end
      if (done) begin
        seen_done = 1'b1;
        if (mode == 1) check_eq("done_cycle", 32'(cyc), 32'(2 * N + 1));
      end
      if (spk_valid && spk_ready) begin
        popped++;
        if (exp_q.size() > 0) check_eq("spk_idx", 32'(spk_idx), 32'(exp_q.pop_front()));
      end
      tick();
      cyc++;
    end
    cfg_we = 1'b0;
    check_eq("done_seen", 32'(seen_done), 32'd1);
    check_eq("done_pulse_len", 32'(done), 32'd0);
    check_eq("busy_after_done", 32'(busy), 32'd0);
    spk_ready = 1'b1;
    for (int j = 0; j < 20 && spk_valid; j++) begin
      popped++;
      if (exp_q.size() > 0) check_eq("spk_idx_drain", 32'(spk_idx), 32'(exp_q.pop_front()));
      tick();
    end
    spk_ready = 1'b0;
    check_eq("spike_count", 32'(popped), 32'(exp_n));
    check_eq("fifo_empty", 32'(spk_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] val;
    int          cyc;
    bit          saw_done;

    // Reset state
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    model_reset();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
    check_eq("rst_spk_valid", 32'(spk_valid), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_neuron(0);
    check_neuron(N - 1);

    // Single spike from neuron 3
    cfg_write(3, 0, 18'h0_5999);
    rd_field(3, 0, val);
    check_eq("wr_readback", 32'(val), 32'h0_5999);
    run_sweep(1, 1'b0);
    rd_field(3, 0, val);
    check_eq("n3_v_reset", 32'(val), 32'h3_8000);
    rd_field(3, 1, val);
    check_eq("n3_u_plus_d", 32'(val), 32'h3_D1EB);
    check_neuron(3);

    // Every neuron spikes with the consumer stalled
    for (int k = 0; k < N; k++) cfg_write(k, 0, 18'h0_5999);
    run_sweep(2, 1'b0);
    check_neuron(15);

    // Saturation at the top of the range without a spike
    cfg_write(0, 7, 18'h1_FFFF);
    cfg_write(0, 0, 18'h1_E666);
    run_sweep(1, 1'b0);
    rd_field(0, 0, val);
    check_eq("v_saturate", 32'(val), 32'h1_FFFF);
    cfg_write(0, 7, 18'h0_4CCC);

    // Spike counter over three sweeps
    cfg_write(5, 8, 18'h0_0000);
    for (int s = 0; s < 3; s++) begin
      cfg_write(5, 0, 18'h0_5999);
      run_sweep(0, 1'b0);
    end
    rd_field(5, 8, val);
`ifdef IZH_SPIKE_COUNT_EN
    check_eq("spike_cnt", 32'(val), 32'd3);
`else
    check_eq("spike_cnt", 32'(val), 32'd0);
`endif

    // Randomized configuration and sweeps, one with a dropped write
    for (int it = 0; it < 6; it++) begin
      for (int w = 0; w < 6; w++) begin
        cfg_write($urandom_range(0, N - 1), $urandom_range(0, 7), 18'($urandom));
      end
      run_sweep(0, it == 2);
    end
    for (int k = 0; k < N; k++) check_neuron(k);

    // Reset in the middle of a sweep
    cfg_write(0, 0, 18'h0_5999);
    spk_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      tick();
      cyc++;
    end
    check_eq("busy_before_abort", 32'(busy), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_reset();
    saw_done = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check_eq("abort_no_done", 32'(saw_done), 32'd0);
    check_eq("abort_fifo_empty", 32'(spk_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    rd_field(0, 0, val);
    check_eq("abort_v_init", 32'(val), 32'h3_4CCD);
    check_neuron(0);
    check_neuron(9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
